// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined adder: each stage adds SEG bits and registers the carry,
// with valid/ready handshaking where an unaccepted result stalls the whole pipe.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / SEG;

    logic stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]         aSeg;
        logic [SEG-1:0]         bSeg;
        logic                   cIn;
        logic                   vIn;
        logic                   aMsbIn;
        logic                   bMsbIn;
        logic [SEG:0]           segRes;
        logic [(k+1)*SEG-1:0]   sNext;

        logic                   vReg;
        logic                   cReg;
        logic                   aMsb;
        logic                   bMsb;
        logic [(k+1)*SEG-1:0]   sReg;

        // Stage 0 reads the ports; later stages read the skew registers of the stage before.
        if (k == 0) begin : g_first
            assign aSeg   = A[SEG-1:0];
            assign bSeg   = B[SEG-1:0];
            assign cIn    = Cin;
            assign vIn    = in_valid;
            assign aMsbIn = A[WIDTH-1];
            assign bMsbIn = B[WIDTH-1];
            assign sNext  = segRes[SEG-1:0];
        end else begin : g_next
            assign aSeg   = g_stage[k-1].g_skew.aSkew[SEG-1:0];
            assign bSeg   = g_stage[k-1].g_skew.bSkew[SEG-1:0];
            assign cIn    = g_stage[k-1].cReg;
            assign vIn    = g_stage[k-1].vReg;
            assign aMsbIn = g_stage[k-1].aMsb;
            assign bMsbIn = g_stage[k-1].bMsb;
            assign sNext  = {segRes[SEG-1:0], g_stage[k-1].sReg};
        end

        assign segRes = {1'b0, aSeg} + {1'b0, bSeg} + {{SEG{1'b0}}, cIn};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vReg <= 1'b0;
                cReg <= 1'b0;
                aMsb <= 1'b0;
                bMsb <= 1'b0;
                sReg <= '0;
            end else if (!stall) begin
                vReg <= vIn;
                cReg <= segRes[SEG];
                aMsb <= aMsbIn;
                bMsb <= bMsbIn;
                sReg <= sNext;
            end
        end

        // Operand bits not yet consumed ride along, shrinking by one segment per stage.
        if (k < STAGES - 1) begin : g_skew
            localparam int REM = WIDTH - (k + 1) * SEG;

            logic [REM-1:0] aSkew;
            logic [REM-1:0] bSkew;
            logic [REM-1:0] aSkewIn;
            logic [REM-1:0] bSkewIn;

            if (k == 0) begin : g_src_port
                assign aSkewIn = A[WIDTH-1:SEG];
                assign bSkewIn = B[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign aSkewIn = g_stage[k-1].g_skew.aSkew[REM+SEG-1:SEG];
                assign bSkewIn = g_stage[k-1].g_skew.bSkew[REM+SEG-1:SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    aSkew <= '0;
                    bSkew <= '0;
                end else if (!stall) begin
                    aSkew <= aSkewIn;
                    bSkew <= bSkewIn;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vReg;
    assign Sum       = g_stage[STAGES-1].sReg;
    assign Cout      = g_stage[STAGES-1].cReg;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // Overflow uses the operand sign bits that travelled alongside the data.
    assign Ovf = (g_stage[STAGES-1].aMsb == g_stage[STAGES-1].bMsb) &&
                 (Sum[WIDTH-1] != g_stage[STAGES-1].aMsb);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: expected results queued on acceptance,
// compared in order whenever the adder presents a result.
module tb_pipelined_adder;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    typedef struct {
        logic [WIDTH+1:0] res;
        int               acc;
    } expT;

    expT q[$];
    int  checks = 0;
    int  errors = 0;
    int  cycle = 0;
    int  accepted = 0;
    bit  checkLat = 0;
    logic lastInReady;
    logic lastOutValid;

    pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {cout, ovf, sum}
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c);
        logic [WIDTH:0] s;
        logic           ovf;
        s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return {s[WIDTH], ovf, s[WIDTH-1:0]};
    endfunction

    // One clock cycle: drive after the falling edge, sample, then let the rising edge transfer.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic ordy);
        expT e;
        @(negedge clk);
        in_valid  = v;
        A         = a;
        B         = b;
        Cin       = c;
        out_ready = ordy;
        #1;
        lastInReady  = in_ready;
        lastOutValid = out_valid;
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !ordy)});
        if (out_valid) begin
            if (q.size() == 0) begin
                checkOutput("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                checkOutput("result", {{(32-WIDTH-2){1'b0}}, Cout, Ovf, Sum},
                            {{(32-WIDTH-2){1'b0}}, q[0].res});
                if (ordy) begin
                    if (checkLat) checkOutput("latency", cycle - q[0].acc, LAT);
                    void'(q.pop_front());
                end
            end
        end
        if (v && in_ready) begin
            e.res = model(a, b, c);
            e.acc = cycle;
            q.push_back(e);
            accepted++;
        end
        @(posedge clk);
        cycle++;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("drain_empty", q.size(), 0);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #2;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_sum", {16'b0, Sum}, 32'd0);
        checkOutput("rst_cout", {31'b0, Cout}, 32'd0);
        checkOutput("rst_ovf", {31'b0, Ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Wrap to zero with carry, then signed overflow, then all-ones plus carry-in
        checkLat = 1;
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        drain();
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
        drain();

        // Eight back-to-back operand sets
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 16'(i), 16'(32'h1000 * i), i[0], 1'b1);
        drain();

        // Fill the pipe, then hold off the consumer for three cycles
        checkLat = 0;
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 16'(32'h1111 * i), 16'h0F0F, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hABCD, 16'h1234, 1'b0, 1'b0);
            checkOutput("stall_out_valid", {31'b0, lastOutValid}, 32'd1);
            checkOutput("stall_in_ready", {31'b0, lastInReady}, 32'd0);
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 16'(32'h2222 * i), 16'h7777, 1'b0, 1'b1);
        drain();

        // Asynchronous reset with the pipe full and a result held at the output
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 16'(32'h0F00 + i), 16'h00F0, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_sum", {16'b0, Sum}, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkLat = 1;
        applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
        drain();

        // Random traffic with random input and output handshakes
        checkLat = 0;
        accepted = 0;
        for (int n = 0; n < 40000 && accepted < 10000; n++)
            applyStimulus($urandom_range(0, 99) < 70, 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), $urandom_range(0, 99) < 70);
        checkOutput("random_accepted", accepted, 10000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
